byte_accum: RTL

Sequential byte-stream accumulator that sits directly upstream of the 8-bit ripple adder stage and reuses the same 8-bit add-with-carry datapath. It accepts a stream of 8-bit operands over a valid/ready handshake and sums each packet into a WIDTH-bit total, one byte slice per cycle, propagating the carry between slices in a flop. When the operand marked last has been added, it presents the total and a sticky overflow flag on a valid/ready output.

---
 rtl/byte_accum.sv | 108 ++++++++++
 1 files changed

// File: rtl/byte_accum.sv
// byte_accum: sequential byte-stream accumulator.
// Operands arrive over a valid/ready handshake and are summed into a
// WIDTH-bit total one byte slice per cycle, with the inter-slice carry held
// in a flop. When the last operand of a packet has been added, the total and
// a sticky overflow flag are offered on a valid/ready output.
module byte_accum #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned KW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_OUT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [KW-1:0]    k_q;
  logic             cy_q;
  logic             lst_q;
  logic             ovf_q;
  logic [7:0]       opnd_q;

  logic [7:0]       cur_slice;
  logic [7:0]       addend;
  logic [8:0]       sum9;
  logic             last_slice;

  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_OUT);
  assign out_sum    = acc_q;
  assign out_ovf    = ovf_q;
  assign last_slice = (k_q == KW'(NBYTES - 1));

  // Shared 8-bit add-with-carry on slice k; the operand enters only at slice 0.
  always_comb begin
    cur_slice = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == KW'(i)) cur_slice = acc_q[i*8 +: 8];
    end
    addend = (k_q == '0) ? opnd_q : '0;
    sum9   = {1'b0, cur_slice} + {1'b0, addend} + {8'b0, cy_q};
    acc_d  = acc_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (k_q == KW'(i)) acc_d[i*8 +: 8] = sum9[7:0];
    end
  end

  // Control FSM and datapath registers; every slice is visited, no early exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      cy_q    <= 1'b0;
      lst_q   <= 1'b0;
      ovf_q   <= 1'b0;
      opnd_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            opnd_q  <= in_data;
            lst_q   <= in_last;
            k_q     <= '0;
            cy_q    <= 1'b0;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          acc_q <= acc_d;
          cy_q  <= sum9[8];
          if (last_slice) begin
            if (sum9[8]) ovf_q <= 1'b1;
            k_q     <= '0;
            state_q <= lst_q ? S_OUT : S_IDLE;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
